// File: rtl/lc3b_hazard_scoreboard_if.sv
// Issue/control bundle between the LC-3b decode/pipeline controller (master)
// and the hazard scoreboard (slave).
interface lc3b_hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             issue_valid;
  logic             issue_regwrite;
  logic [2:0]       issue_dr;
  logic             issue_set_r7;
  logic             issue_is_ld;
  logic [2:0]       issue_sr1;
  logic             issue_sr1_used;
  logic [2:0]       issue_sr2;
  logic             issue_sr2_used;
  logic             mem_stall;
  logic             flush;
  logic             stats_clr;
  logic             load_use_stall;
  logic [7:0]       pending_mask;
  logic [7:0]       ld_pending_mask;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output issue_valid, issue_regwrite, issue_dr, issue_set_r7, issue_is_ld,
           issue_sr1, issue_sr1_used, issue_sr2, issue_sr2_used,
           mem_stall, flush, stats_clr,
    input  load_use_stall, pending_mask, ld_pending_mask, stall_count
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_dr, issue_set_r7, issue_is_ld,
           issue_sr1, issue_sr1_used, issue_sr2, issue_sr2_used,
           mem_stall, flush, stats_clr,
    output load_use_stall, pending_mask, ld_pending_mask, stall_count
  );
endinterface

// File: rtl/lc3b_hazard_scoreboard.sv
// Tracks in-flight GPR writes in ID/EX, EX/MEM, MEM/WB and raises the load-use stall.
// Define LC3B_SCOREBOARD_STATS_EN to build the saturating stall counter.
module lc3b_hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  lc3b_hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [2:0] dr;
    logic       ld;
  } token_t;

  // Index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
  token_t     slot_q [3];
  token_t     slot_d [3];
  token_t     issue_tok;
  logic       src_match;
  logic       load_use_stall;
  logic [7:0] pend_w;
  logic [7:0] ld_pend_w;

  always_comb begin
    issue_tok.valid = 1'b1;
    issue_tok.wr    = sb.issue_regwrite | sb.issue_set_r7;
    issue_tok.dr    = sb.issue_set_r7 ? 3'b111 : sb.issue_dr;
    issue_tok.ld    = sb.issue_is_ld;
  end

  // Only a load still in ID/EX is beyond forwarding; once in EX/MEM, MEM/WB forwards it.
  assign src_match = (sb.issue_sr1_used && (sb.issue_sr1 == slot_q[0].dr)) ||
                     (sb.issue_sr2_used && (sb.issue_sr2 == slot_q[0].dr));
  assign load_use_stall = sb.issue_valid & ~sb.flush & slot_q[0].valid &
                          slot_q[0].wr & slot_q[0].ld & src_match;

  always_comb begin
    slot_d = slot_q;
    if (!sb.mem_stall) begin
      slot_d[2] = slot_q[1];
      // A flush only bubbles ID/EX; the older s0 token still moves on behind the branch.
      slot_d[1] = slot_q[0];
      slot_d[0] = (sb.issue_valid && !load_use_stall && !sb.flush) ? issue_tok : '0;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          slot_q[gi] <= '0;
        end else begin
          slot_q[gi] <= slot_d[gi];
        end
      end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign pend_w[gi] =
          (slot_q[0].valid && slot_q[0].wr && (slot_q[0].dr == 3'(gi))) ||
          (slot_q[1].valid && slot_q[1].wr && (slot_q[1].dr == 3'(gi))) ||
          (slot_q[2].valid && slot_q[2].wr && (slot_q[2].dr == 3'(gi)));
      assign ld_pend_w[gi] =
          (slot_q[0].valid && slot_q[0].wr && slot_q[0].ld && (slot_q[0].dr == 3'(gi))) ||
          (slot_q[1].valid && slot_q[1].wr && slot_q[1].ld && (slot_q[1].dr == 3'(gi)));
    end
  endgenerate

  assign sb.load_use_stall  = load_use_stall;
  assign sb.pending_mask    = pend_w;
  assign sb.ld_pending_mask = ld_pend_w;

`ifdef LC3B_SCOREBOARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (sb.stats_clr) begin
      stall_cnt_d = '0;
    end else if (load_use_stall && !sb.mem_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.stall_count = stall_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = sb.stats_clr;
  assign sb.stall_count   = '0;
`endif

endmodule

// File: tb/tb_lc3b_hazard_scoreboard.sv
// Self-checking bench for lc3b_hazard_scoreboard: directed scenarios plus random
// issue traffic against an in-flight-instruction queue model.
module tb_lc3b_hazard_scoreboard;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_hazard_scoreboard_if #(.CNT_W(CNT_W)) sb_if ();

  lc3b_hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sb     (sb_if.slave)
  );

  typedef struct {
    bit       v;
    bit       rw;
    bit [2:0] dr;
    bit       r7;
    bit       ld;
    bit [2:0] sr1;
    bit       u1;
    bit [2:0] sr2;
    bit       u2;
    bit       ms;
    bit       fl;
    bit       clr;
  } stim_t;

  // One in-flight instruction as the pipeline sees it; index 0 is the youngest.
  typedef struct {
    bit valid;
    bit wr;
    int dr;
    bit ld;
  } ent_t;

  ent_t pipe[$];
  int   m_cnt;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_step = 0;

  logic             obs_stall;
  logic [7:0]       obs_pend;
  logic [7:0]       obs_ldp;
  logic [CNT_W-1:0] obs_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t f_ld(input int dr, input int base);
    stim_t s = idle();
    s.v = 1; s.rw = 1; s.dr = 3'(dr); s.ld = 1; s.sr1 = 3'(base); s.u1 = 1;
    return s;
  endfunction

  function automatic stim_t f_add(input int dr, input int a, input int b);
    stim_t s = idle();
    s.v = 1; s.rw = 1; s.dr = 3'(dr); s.sr1 = 3'(a); s.u1 = 1; s.sr2 = 3'(b); s.u2 = 1;
    return s;
  endfunction

  function automatic stim_t f_st(input int base, input int src);
    stim_t s = idle();
    s.v = 1; s.sr1 = 3'(base); s.u1 = 1; s.sr2 = 3'(src); s.u2 = 1;
    return s;
  endfunction

  function automatic stim_t f_jsr();
    stim_t s = idle();
    s.v = 1; s.r7 = 1; s.dr = 3'd2;
    return s;
  endfunction

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back('{0, 0, 0, 0});
    m_cnt = 0;
  endfunction

  function automatic bit model_stall(input stim_t s);
    ent_t y = pipe[0];
    if (!s.v || s.fl) return 0;
    return y.valid && y.wr && y.ld &&
           ((s.u1 && int'(s.sr1) == y.dr) || (s.u2 && int'(s.sr2) == y.dr));
  endfunction

  function automatic logic [7:0] model_mask(input bit ld_only);
    logic [7:0] m = '0;
    for (int i = 0; i < (ld_only ? 2 : 3); i++)
      if (pipe[i].valid && pipe[i].wr && (!ld_only || pipe[i].ld)) m[pipe[i].dr] = 1'b1;
    return m;
  endfunction

  function automatic void model_advance(input stim_t s, input bit stall);
    ent_t e;
    `ifdef LC3B_SCOREBOARD_STATS_EN
    if (s.clr) m_cnt = 0;
    else if (stall && !s.ms && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    `endif
    if (s.ms) return;
    e = '{0, 0, 0, 0};
    if (s.v && !stall && !s.fl) begin
      e.valid = 1;
      e.wr    = s.rw || s.r7;
      e.dr    = s.r7 ? 7 : int'(s.dr);
      e.ld    = s.ld;
    end
    void'(pipe.pop_back());
    pipe.push_front(e);
  endfunction

  task automatic drive(input stim_t s);
    sb_if.issue_valid    = s.v;
    sb_if.issue_regwrite = s.rw;
    sb_if.issue_dr       = s.dr;
    sb_if.issue_set_r7   = s.r7;
    sb_if.issue_is_ld    = s.ld;
    sb_if.issue_sr1      = s.sr1;
    sb_if.issue_sr1_used = s.u1;
    sb_if.issue_sr2      = s.sr2;
    sb_if.issue_sr2_used = s.u2;
    sb_if.mem_stall      = s.ms;
    sb_if.flush          = s.fl;
    sb_if.stats_clr      = s.clr;
  endtask

  // Entered at posedge+1; checks combinational and state outputs mid-cycle, then clocks.
  task automatic step(input stim_t s);
    bit exp_stall;
    drive(s);
    #2;
    exp_stall = model_stall(s);
    obs_stall = sb_if.load_use_stall;
    obs_pend  = sb_if.pending_mask;
    obs_ldp   = sb_if.ld_pending_mask;
    obs_cnt   = sb_if.stall_count;
    check_val("load_use_stall", 32'(obs_stall), 32'(exp_stall));
    check_val("pending_mask", 32'(obs_pend), 32'(model_mask(0)));
    check_val("ld_pending_mask", 32'(obs_ldp), 32'(model_mask(1)));
    check_val("stall_count", 32'(obs_cnt), 32'(m_cnt));
    $display("step %0d v=%0b rw=%0b dr=%0d r7=%0b ld=%0b sr1=%0d/%0b sr2=%0d/%0b ms=%0b fl=%0b clr=%0b -> stall=%0b pend=%02h ldp=%02h cnt=%0d",
             n_step, s.v, s.rw, s.dr, s.r7, s.ld, s.sr1, s.u1, s.sr2, s.u2, s.ms, s.fl, s.clr,
             obs_stall, obs_pend, obs_ldp, obs_cnt);
    n_step++;
    @(posedge clk);
    model_advance(s, exp_stall);
    #1;
  endtask

  task automatic drain();
    stim_t s = idle();
    s.clr = 1;
    step(s);
    step(idle());
    step(idle());
  endtask

  initial begin
    stim_t s;
    model_reset();
    drive(idle());
    #7;
    check_val("reset_pending", 32'(sb_if.pending_mask), 32'h0);
    check_val("reset_ld_pending", 32'(sb_if.ld_pending_mask), 32'h0);
    check_val("reset_stall", 32'(sb_if.load_use_stall), 32'h0);
    check_val("reset_count", 32'(sb_if.stall_count), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Load followed directly by a dependent ADD: one bubble, then ADD issues.
    drain();
    step(f_ld(3, 6));
    check_val("lu_first_no_stall", 32'(obs_stall), 32'h0);
    step(f_add(1, 3, 2));
    check_val("lu_stall", 32'(obs_stall), 32'h1);
    step(f_add(1, 3, 2));
    check_val("lu_stall_one_cycle", 32'(obs_stall), 32'h0);
    check_val("lu_bubble_pend", 32'(obs_pend), 32'h08);
    step(idle());
    check_val("lu_add_issued", 32'(obs_pend), 32'h0A);
    `ifdef LC3B_SCOREBOARD_STATS_EN
    check_val("lu_count", 32'(obs_cnt), 32'h1);
    `endif

    // Load, independent gap, dependent ADD: no stall.
    drain();
    step(f_ld(3, 6));
    step(idle());
    check_val("gap_ldp_1", 32'(obs_ldp), 32'h08);
    step(f_add(1, 3, 2));
    check_val("gap_no_stall", 32'(obs_stall), 32'h0);
    check_val("gap_ldp_2", 32'(obs_ldp), 32'h08);
    step(idle());
    check_val("gap_ldp_clear", 32'(obs_ldp), 32'h00);

    // Store data dependent on LDB while memory is frozen.
    drain();
    s = f_ld(3, 6);
    step(s);
    for (int k = 0; k < 4; k++) begin
      s = f_st(6, 3);
      s.ms = 1;
      step(s);
      check_val("frz_stall", 32'(obs_stall), 32'h1);
      check_val("frz_pend", 32'(obs_pend), 32'h08);
      check_val("frz_ldp", 32'(obs_ldp), 32'h08);
    end
    step(f_st(6, 3));
    check_val("frz_release_stall", 32'(obs_stall), 32'h1);
    step(f_st(6, 3));
    check_val("frz_after_stall", 32'(obs_stall), 32'h0);
    `ifdef LC3B_SCOREBOARD_STATS_EN
    check_val("frz_count", 32'(obs_cnt), 32'h1);
    `endif

    // JSR then use of R7: no stall, R7 pending for three advances.
    drain();
    step(f_jsr());
    s = idle();
    s.v = 1; s.rw = 1; s.dr = 0; s.sr1 = 7; s.u1 = 1;
    step(s);
    check_val("jsr_no_stall", 32'(obs_stall), 32'h0);
    check_val("jsr_r7_a", 32'(obs_pend[7]), 32'h1);
    step(idle());
    check_val("jsr_r7_b", 32'(obs_pend[7]), 32'h1);
    step(idle());
    check_val("jsr_r7_c", 32'(obs_pend[7]), 32'h1);
    step(idle());
    check_val("jsr_r7_gone", 32'(obs_pend[7]), 32'h0);

    // Flush on a would-be stalling issue.
    drain();
    step(f_ld(3, 6));
    s = f_add(1, 3, 2);
    s.fl = 1;
    step(s);
    check_val("flush_no_stall", 32'(obs_stall), 32'h0);
    step(idle());
    check_val("flush_bubble_pend", 32'(obs_pend), 32'h08);
    check_val("flush_ldp", 32'(obs_ldp), 32'h08);

    // Asynchronous reset with three writes in flight and a stall pending.
    drain();
    step(f_add(1, 5, 5));
    step(f_add(2, 5, 5));
    step(f_ld(4, 6));
    drive(f_add(0, 4, 0));
    #2;
    check_val("pre_reset_pend", 32'(sb_if.pending_mask), 32'h16);
    check_val("pre_reset_stall", 32'(sb_if.load_use_stall), 32'h1);
    reset_n = 1'b0;
    #1;
    check_val("async_reset_pend", 32'(sb_if.pending_mask), 32'h00);
    check_val("async_reset_ldp", 32'(sb_if.ld_pending_mask), 32'h00);
    check_val("async_reset_stall", 32'(sb_if.load_use_stall), 32'h0);
    check_val("async_reset_count", 32'(sb_if.stall_count), 32'h0);
    model_reset();
    drive(idle());
    @(posedge clk); #1;
    reset_n = 1'b1;

    `ifdef LC3B_SCOREBOARD_STATS_EN
    // Drive the counter past saturation, then clear it.
    drain();
    for (int k = 0; k < (1 << CNT_W) + 5; k++) begin
      step(f_ld(3, 6));
      step(f_ld(3, 3));
    end
    step(idle());
    check_val("sat_hold", 32'(obs_cnt), 32'((1 << CNT_W) - 1));
    s = idle();
    s.clr = 1;
    step(s);
    step(idle());
    check_val("sat_clear", 32'(obs_cnt), 32'h0);
    `endif

    // Random traffic with a small register window so hazards are frequent.
    for (int k = 0; k < 600; k++) begin
      int r;
      s = idle();
      s.v   = ($urandom_range(0, 9) != 0);
      s.rw  = $urandom_range(0, 1);
      s.r7  = ($urandom_range(0, 9) == 0);
      s.ld  = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 4); s.dr  = (r == 4) ? 3'd7 : 3'(r);
      r = $urandom_range(0, 4); s.sr1 = (r == 4) ? 3'd7 : 3'(r);
      r = $urandom_range(0, 4); s.sr2 = (r == 4) ? 3'd7 : 3'(r);
      s.u1  = $urandom_range(0, 1);
      s.u2  = $urandom_range(0, 1);
      s.ms  = ($urandom_range(0, 4) == 0);
      s.fl  = ($urandom_range(0, 9) == 0);
      s.clr = ($urandom_range(0, 49) == 0);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
